// File: rtl/stack_1r1w_ramwrap_ctrl.sv
// Banked 1R1W SRAM wrapper: low address bits pick the bank, the remaining bits the row.
// Optional same-cycle write-to-read bypass is enabled by defining STACK_1R1W_RDWR_BYPASS_EN.
`default_nettype none

module stack_1r1w_ramwrap_pipe #(
  parameter int W     = 1,
  parameter int DEPTH = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  localparam int D1 = (DEPTH > 0) ? DEPTH : 1;

  logic [D1-1:0][W-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < D1; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) pipe_q <= '0;
    else     pipe_q <= pipe_d;
  end

  assign dout = (DEPTH == 0) ? din : pipe_q[D1-1];
endmodule

module stack_1r1w_ramwrap_ctrl #(
  parameter int WIDTH      = 32,
  parameter int NUMADDR    = 1024,
  parameter int BITADDR    = 10,
  parameter int NUMWBNK    = 4,
  parameter int BITWBNK    = 2,
  parameter int NUMWROW    = 256,
  parameter int BITWROW    = 8,
  parameter int SRAM_DELAY = 2,
  parameter int FLOPCMD    = 0,
  parameter int FLOPMEM    = 0,
  parameter int FLOPOUT    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       write,
  input  logic [BITADDR-1:0]         wr_adr,
  input  logic [WIDTH-1:0]           bw,
  input  logic [WIDTH-1:0]           din,
  input  logic                       read,
  input  logic [BITADDR-1:0]         rd_adr,
  output logic                       rd_vld,
  output logic [WIDTH-1:0]           rd_dout,
  output logic                       rd_err,
  output logic [NUMWBNK-1:0]         mem_write,
  output logic [NUMWBNK-1:0]         mem_read,
  output logic [NUMWBNK*BITWROW-1:0] mem_wr_adr,
  output logic [NUMWBNK*BITWROW-1:0] mem_rd_adr,
  output logic [NUMWBNK*WIDTH-1:0]   mem_bw,
  output logic [NUMWBNK*WIDTH-1:0]   mem_din,
  input  logic [NUMWBNK*WIDTH-1:0]   mem_rd_dout
);
  localparam int BB       = (BITWBNK > 0) ? BITWBNK : 1;
  localparam int CAP      = NUMWBNK * NUMWROW;
  localparam int MAXADR   = (NUMADDR < CAP) ? NUMADDR : CAP;
  localparam logic [31:0] MAXADR_U = 32'(MAXADR);

  typedef struct packed {
    logic               write;
    logic [BITADDR-1:0] wr_adr;
    logic [WIDTH-1:0]   bw;
    logic [WIDTH-1:0]   din;
    logic               read;
    logic [BITADDR-1:0] rd_adr;
  } cmd_t;

  typedef struct packed {
    logic [NUMWBNK-1:0]         write;
    logic [NUMWBNK-1:0]         read;
    logic [NUMWBNK*BITWROW-1:0] wr_adr;
    logic [NUMWBNK*BITWROW-1:0] rd_adr;
    logic [NUMWBNK*WIDTH-1:0]   bw;
    logic [NUMWBNK*WIDTH-1:0]   din;
  } mem_t;

  // Read-side bookkeeping that travels alongside the SRAM access.
  typedef struct packed {
    logic          vld;
    logic [BB-1:0] bank;
`ifdef STACK_1R1W_RDWR_BYPASS_EN
    logic          byp;
    logic [WIDTH-1:0] bw;
    logic [WIDTH-1:0] din;
`endif
  } rmeta_t;

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] dout;
  } rout_t;

  cmd_t   cmd_in, cmd;
  mem_t   mem_d, mem_m;
  rmeta_t meta_d, meta_m, meta_s;
  rout_t  out_d, out_o;
  logic   wr_in, rd_in, wr_ok, rd_ok;
  logic [BB-1:0]      wr_bank, rd_bank;
  logic [BITWROW-1:0] wr_row, rd_row;
  logic [WIDTH-1:0]   sel;
  logic rd_err_q, rd_err_d;

  always_comb begin
    cmd_in        = '0;
    cmd_in.write  = write;
    cmd_in.wr_adr = wr_adr;
    cmd_in.bw     = bw;
    cmd_in.din    = din;
    cmd_in.read   = read;
    cmd_in.rd_adr = rd_adr;
  end

  stack_1r1w_ramwrap_pipe #(.W($bits(cmd_t)), .DEPTH(FLOPCMD)) u_cmd_pipe (
    .clk(clk), .rst(rst), .din(cmd_in), .dout(cmd)
  );

  always_comb begin
    wr_in   = 32'(cmd.wr_adr) < MAXADR_U;
    rd_in   = 32'(cmd.rd_adr) < MAXADR_U;
    wr_ok   = cmd.write && wr_in && !rst;
    rd_ok   = cmd.read  && rd_in && !rst;
    wr_bank = BB'(cmd.wr_adr % NUMWBNK);
    rd_bank = BB'(cmd.rd_adr % NUMWBNK);
    wr_row  = BITWROW'(cmd.wr_adr / NUMWBNK);
    rd_row  = BITWROW'(cmd.rd_adr / NUMWBNK);

    mem_d = '0;
    if (wr_ok) begin
      mem_d.write[wr_bank]                          = 1'b1;
      mem_d.wr_adr[wr_bank*BITWROW +: BITWROW]      = wr_row;
      mem_d.bw[wr_bank*WIDTH +: WIDTH]              = cmd.bw;
      mem_d.din[wr_bank*WIDTH +: WIDTH]             = cmd.din;
    end
    if (rd_ok) begin
      mem_d.read[rd_bank]                           = 1'b1;
      mem_d.rd_adr[rd_bank*BITWROW +: BITWROW]      = rd_row;
    end

    meta_d      = '0;
    meta_d.vld  = rd_ok;
    meta_d.bank = rd_ok ? rd_bank : '0;
`ifdef STACK_1R1W_RDWR_BYPASS_EN
    meta_d.byp  = rd_ok && wr_ok && (cmd.wr_adr == cmd.rd_adr);
    meta_d.bw   = meta_d.byp ? cmd.bw  : '0;
    meta_d.din  = meta_d.byp ? cmd.din : '0;
`endif

    rd_err_d = rd_err_q | (cmd.write && !wr_in) | (cmd.read && !rd_in);
  end

  always_ff @(posedge clk) begin
    if (rst) rd_err_q <= 1'b0;
    else     rd_err_q <= rd_err_d;
  end

  stack_1r1w_ramwrap_pipe #(.W($bits(mem_t) + $bits(rmeta_t)), .DEPTH(FLOPMEM)) u_mem_pipe (
    .clk(clk), .rst(rst), .din({mem_d, meta_d}), .dout({mem_m, meta_m})
  );

  assign mem_write  = mem_m.write;
  assign mem_read   = mem_m.read;
  assign mem_wr_adr = mem_m.wr_adr;
  assign mem_rd_adr = mem_m.rd_adr;
  assign mem_bw     = mem_m.bw;
  assign mem_din    = mem_m.din;

  // Bank index waits out the SRAM latency so the right bank's data is picked.
  stack_1r1w_ramwrap_pipe #(.W($bits(rmeta_t)), .DEPTH(SRAM_DELAY)) u_sram_pipe (
    .clk(clk), .rst(rst), .din(meta_m), .dout(meta_s)
  );

  always_comb begin
    sel = mem_rd_dout[meta_s.bank*WIDTH +: WIDTH];
`ifdef STACK_1R1W_RDWR_BYPASS_EN
    if (meta_s.byp) sel = (meta_s.bw & meta_s.din) | (~meta_s.bw & sel);
`endif
    out_d      = '0;
    out_d.vld  = meta_s.vld;
    out_d.dout = meta_s.vld ? sel : '0;
  end

  stack_1r1w_ramwrap_pipe #(.W($bits(rout_t)), .DEPTH(FLOPOUT)) u_out_pipe (
    .clk(clk), .rst(rst), .din(out_d), .dout(out_o)
  );

  assign rd_vld  = out_o.vld;
  assign rd_dout = out_o.dout;
  assign rd_err  = rd_err_q;
endmodule

`default_nettype wire

// File: tb/tb_stack_1r1w_ramwrap_ctrl.sv
// Directed bench: default-config DUT driven from a vector table, plus a registered,
// 11-bit-address DUT for latency and out-of-range sequences; both backed by behavioural SRAMs.
module tb_stack_1r1w_ramwrap_ctrl;
  logic clk, rst;
  int checks = 0, failures = 0;

`ifdef STACK_1R1W_RDWR_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'hFF000000;
`else
  localparam logic [31:0] BYP_EXP = 32'h00000000;
`endif

  logic a_write, a_read;
  logic [9:0] a_wr_adr, a_rd_adr;
  logic [31:0] a_bw, a_din, a_rd_dout;
  logic a_rd_vld, a_rd_err;
  logic [3:0] a_mem_write, a_mem_read;
  logic [31:0] a_mem_wr_adr, a_mem_rd_adr;
  logic [127:0] a_mem_bw, a_mem_din, a_mem_rd_dout;

  logic b_write, b_read;
  logic [10:0] b_wr_adr, b_rd_adr;
  logic [31:0] b_bw, b_din, b_rd_dout;
  logic b_rd_vld, b_rd_err;
  logic [3:0] b_mem_write, b_mem_read;
  logic [31:0] b_mem_wr_adr, b_mem_rd_adr;
  logic [127:0] b_mem_bw, b_mem_din, b_mem_rd_dout;

  stack_1r1w_ramwrap_ctrl u_a (
    .clk(clk), .rst(rst), .write(a_write), .wr_adr(a_wr_adr), .bw(a_bw), .din(a_din),
    .read(a_read), .rd_adr(a_rd_adr), .rd_vld(a_rd_vld), .rd_dout(a_rd_dout), .rd_err(a_rd_err),
    .mem_write(a_mem_write), .mem_read(a_mem_read), .mem_wr_adr(a_mem_wr_adr),
    .mem_rd_adr(a_mem_rd_adr), .mem_bw(a_mem_bw), .mem_din(a_mem_din), .mem_rd_dout(a_mem_rd_dout)
  );

  stack_1r1w_ramwrap_ctrl #(.BITADDR(11), .FLOPCMD(1), .FLOPMEM(1), .FLOPOUT(1)) u_b (
    .clk(clk), .rst(rst), .write(b_write), .wr_adr(b_wr_adr), .bw(b_bw), .din(b_din),
    .read(b_read), .rd_adr(b_rd_adr), .rd_vld(b_rd_vld), .rd_dout(b_rd_dout), .rd_err(b_rd_err),
    .mem_write(b_mem_write), .mem_read(b_mem_read), .mem_wr_adr(b_mem_wr_adr),
    .mem_rd_adr(b_mem_rd_adr), .mem_bw(b_mem_bw), .mem_din(b_mem_din), .mem_rd_dout(b_mem_rd_dout)
  );

  // Behavioural SRAMs: 4 banks x 256 rows, read data two cycles after the read enable.
  logic [31:0] mem_a [4][256] = '{default: '0};
  logic [31:0] mem_b [4][256] = '{default: '0};
  logic [127:0] pa1 = '0, pa2 = '0, pb1 = '0, pb2 = '0;
  assign a_mem_rd_dout = pa2;
  assign b_mem_rd_dout = pb2;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (a_mem_write[b])
        mem_a[b][a_mem_wr_adr[b*8 +: 8]] <= (mem_a[b][a_mem_wr_adr[b*8 +: 8]] & ~a_mem_bw[b*32 +: 32])
                                          | (a_mem_din[b*32 +: 32] & a_mem_bw[b*32 +: 32]);
      if (a_mem_read[b]) pa1[b*32 +: 32] <= mem_a[b][a_mem_rd_adr[b*8 +: 8]];
      if (b_mem_write[b])
        mem_b[b][b_mem_wr_adr[b*8 +: 8]] <= (mem_b[b][b_mem_wr_adr[b*8 +: 8]] & ~b_mem_bw[b*32 +: 32])
                                          | (b_mem_din[b*32 +: 32] & b_mem_bw[b*32 +: 32]);
      if (b_mem_read[b]) pb1[b*32 +: 32] <= mem_b[b][b_mem_rd_adr[b*8 +: 8]];
    end
    pa2 <= pa1;
    pb2 <= pb1;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic wr; logic [9:0] wa; logic [31:0] bw; logic [31:0] din;
    logic rd; logic [9:0] ra;
    logic [3:0] e_mw; logic [3:0] e_mr; logic [31:0] e_wadr;
    logic e_vld; logic [31:0] e_dout;
  } vec_t;

  function automatic vec_t V(input logic wr, input logic [9:0] wa, input logic [31:0] bw,
                             input logic [31:0] din, input logic rd, input logic [9:0] ra,
                             input logic [3:0] e_mw, input logic [3:0] e_mr, input logic [31:0] e_wadr,
                             input logic e_vld, input logic [31:0] e_dout);
    vec_t v;
    v.wr = wr; v.wa = wa; v.bw = bw; v.din = din; v.rd = rd; v.ra = ra;
    v.e_mw = e_mw; v.e_mr = e_mr; v.e_wadr = e_wadr; v.e_vld = e_vld; v.e_dout = e_dout;
    return v;
  endfunction

  task automatic idle_all();
    a_write = 0; a_wr_adr = '0; a_bw = '0; a_din = '0; a_read = 0; a_rd_adr = '0;
    b_write = 0; b_wr_adr = '0; b_bw = '0; b_din = '0; b_read = 0; b_rd_adr = '0;
  endtask

  vec_t vt [26];
  localparam logic [31:0] ONES = 32'hFFFFFFFF;

  initial begin
    vt[0]  = V(1, 5, ONES, 32'hA5A5A5A5, 0, 0, 4'b0010, 4'b0000, 32'h00000100, 0, 0);
    vt[1]  = V(0, 0, 0, 0, 1, 5, 4'b0000, 4'b0010, 0, 0, 0);
    vt[2]  = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[3]  = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA5A5A5A5);
    vt[4]  = V(1, 0, ONES, 32'h11111111, 0, 0, 4'b0001, 0, 0, 0, 0);
    vt[5]  = V(1, 1, ONES, 32'h22222222, 0, 0, 4'b0010, 0, 0, 0, 0);
    vt[6]  = V(1, 2, ONES, 32'h33333333, 0, 0, 4'b0100, 0, 0, 0, 0);
    vt[7]  = V(1, 3, ONES, 32'h44444444, 0, 0, 4'b1000, 0, 0, 0, 0);
    vt[8]  = V(0, 0, 0, 0, 1, 0, 0, 4'b0001, 0, 0, 0);
    vt[9]  = V(0, 0, 0, 0, 1, 1, 0, 4'b0010, 0, 0, 0);
    vt[10] = V(0, 0, 0, 0, 1, 2, 0, 4'b0100, 0, 1, 32'h11111111);
    vt[11] = V(0, 0, 0, 0, 1, 3, 0, 4'b1000, 0, 1, 32'h22222222);
    vt[12] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h33333333);
    vt[13] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h44444444);
    vt[14] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[15] = V(1, 7, 32'hFF00FF00, 32'hFFFF0000, 1, 7, 4'b1000, 4'b1000, 32'h01000000, 0, 0);
    vt[16] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[17] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, BYP_EXP);
    vt[18] = V(0, 0, 0, 0, 1, 7, 0, 4'b1000, 0, 0, 0);
    vt[19] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[20] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFF000000);
    vt[21] = V(1, 5, 32'h0000FFFF, 32'h12345678, 1, 2, 4'b0010, 4'b0100, 32'h00000100, 0, 0);
    vt[22] = V(0, 0, 0, 0, 1, 5, 0, 4'b0010, 0, 0, 0);
    vt[23] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h33333333);
    vt[24] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA5A55678);
    vt[25] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    idle_all();
    rst = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_a_mem_write", 64'(a_mem_write), 0);
    chk("rst_a_mem_read", 64'(a_mem_read), 0);
    chk("rst_a_rd_vld", 64'(a_rd_vld), 0);
    chk("rst_b_mem_write", 64'(b_mem_write), 0);
    chk("rst_b_rd_vld", 64'(b_rd_vld), 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("post_rst_a_rd_err", 64'(a_rd_err), 0);
    chk("post_rst_b_rd_err", 64'(b_rd_err), 0);
    chk("post_rst_a_rd_dout", 64'(a_rd_dout), 0);

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      a_write = vt[i].wr; a_wr_adr = vt[i].wa; a_bw = vt[i].bw; a_din = vt[i].din;
      a_read = vt[i].rd; a_rd_adr = vt[i].ra;
      #1;
      chk($sformatf("v%0d_mem_write", i), 64'(a_mem_write), 64'(vt[i].e_mw));
      chk($sformatf("v%0d_mem_read", i), 64'(a_mem_read), 64'(vt[i].e_mr));
      chk($sformatf("v%0d_mem_wr_adr", i), 64'(a_mem_wr_adr), 64'(vt[i].e_wadr));
      chk($sformatf("v%0d_rd_vld", i), 64'(a_rd_vld), 64'(vt[i].e_vld));
      chk($sformatf("v%0d_rd_dout", i), 64'(a_rd_dout), 64'(vt[i].e_dout));
    end
    chk("a_rd_err_clean", 64'(a_rd_err), 0);

    // Read in flight when reset hits must never produce rd_vld.
    @(negedge clk);
    idle_all(); a_read = 1; a_rd_adr = 5;
    #1 chk("inflight_mem_read", 64'(a_mem_read), 64'(4'b0010));
    @(negedge clk);
    rst = 1; a_read = 1; a_rd_adr = 0; a_write = 1; a_wr_adr = 0; a_bw = ONES; a_din = 32'hBAD0BAD0;
    #1;
    chk("rst_gate_mem_read", 64'(a_mem_read), 0);
    chk("rst_gate_mem_write", 64'(a_mem_write), 0);
    chk("rst_inflight_vld0", 64'(a_rd_vld), 0);
    @(negedge clk);
    #1;
    chk("rst2_gate_mem_read", 64'(a_mem_read), 0);
    chk("rst2_inflight_vld", 64'(a_rd_vld), 0);
    @(negedge clk);
    rst = 0; idle_all();
    for (int k = 0; k < 6; k++) begin
      #1 chk($sformatf("post_rst_no_vld_%0d", k), 64'(a_rd_vld), 0);
      @(negedge clk);
    end

    // Registered configuration: write 1023 then read it back, latency 5.
    b_write = 1; b_wr_adr = 11'd1023; b_bw = ONES; b_din = 32'hDEADBEEF;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      idle_all();
      #1;
      if (k == 2) begin
        chk("b_wr_mem_write", 64'(b_mem_write), 64'(4'b1000));
        chk("b_wr_mem_wr_adr", 64'(b_mem_wr_adr), 64'(32'hFF000000));
      end
    end
    chk("b_rd_err_valid_write", 64'(b_rd_err), 0);

    @(negedge clk);
    b_read = 1; b_rd_adr = 11'd1023;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      idle_all();
      #1;
      chk($sformatf("b_lat_mem_read_%0d", k), 64'(b_mem_read), (k == 2) ? 64'(4'b1000) : 64'd0);
      chk($sformatf("b_lat_rd_vld_%0d", k), 64'(b_rd_vld), (k == 5) ? 64'd1 : 64'd0);
      if (k == 5) chk("b_lat_rd_dout", 64'(b_rd_dout), 64'(32'hDEADBEEF));
    end

    // Out-of-range read: dropped, sticky error until reset.
    @(negedge clk);
    b_read = 1; b_rd_adr = 11'd1024;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      idle_all();
      #1;
      chk($sformatf("b_oor_mem_read_%0d", k), 64'(b_mem_read), 0);
      chk($sformatf("b_oor_rd_vld_%0d", k), 64'(b_rd_vld), 0);
    end
    chk("b_oor_rd_err", 64'(b_rd_err), 1);
    repeat (5) @(negedge clk);
    #1 chk("b_oor_rd_err_sticky", 64'(b_rd_err), 1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1 chk("b_rd_err_cleared", 64'(b_rd_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stack_1r1w_ramwrap_ctrl.md
STACK_1R1W_RAMWRAP_CTRL -- requirements
Module: stack_1r1w_ramwrap_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/bit-enable width.
REQ-002 SHALL have parameters NUMADDR/BITADDR, defaults 1024/10, logical depth and address width.
REQ-003 SHALL have parameters NUMWBNK/BITWBNK, defaults 4/2, bank count and bank-index width (BITWBNK=0 means one bank).
REQ-004 SHALL have parameters NUMWROW/BITWROW, defaults 256/8, rows per bank and row width; NUMADDR <= NUMWBNK*NUMWROW.
REQ-005 SHALL have parameters SRAM_DELAY, FLOPCMD, FLOPMEM, FLOPOUT, defaults 2/0/0/0, pipeline stage counts.
REQ-006 clk  in  1  clock; all state on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 write  in  1  logical write request.
REQ-009 wr_adr  in  BITADDR  write address.
REQ-010 bw  in  WIDTH  per-bit write enable.
REQ-011 din  in  WIDTH  write data.
REQ-012 read  in  1  logical read request.
REQ-013 rd_adr  in  BITADDR  read address.
REQ-014 rd_vld  out  1  rd_dout valid strobe.
REQ-015 rd_dout  out  WIDTH  read data.
REQ-016 rd_err  out  1  sticky out-of-range flag.
REQ-017 mem_write/mem_read  out  NUMWBNK each  per-bank write/read enables.
REQ-018 mem_wr_adr/mem_rd_adr  out  NUMWBNK*BITWROW each  per-bank row addresses, bank b at slice b.
REQ-019 mem_bw/mem_din  out  NUMWBNK*WIDTH each  per-bank bit enable and data.
REQ-020 mem_rd_dout  in  NUMWBNK*WIDTH  per-bank read data, valid SRAM_DELAY cycles after mem_read.

Function
REQ-021 Decode SHALL be bank = adr mod NUMWBNK, row = adr div NUMWBNK; BITWBNK=0 gives bank 0, row = adr.
REQ-022 Command path SHALL register write/read/adr/bw/din FLOPCMD times before decode, then register mem_* outputs FLOPMEM times.
REQ-023 Exactly one bank SHALL be enabled per accepted command; unselected bank enables 0, their addr/data slices 0.
REQ-024 Read and write to different or same banks in the same cycle SHALL both issue (independent 1R and 1W ports).
REQ-025 Read bank index SHALL be carried in a shift pipeline of depth SRAM_DELAY and used to select mem_rd_dout.
REQ-026 Selected data SHALL be registered FLOPOUT times; total read latency L = FLOPCMD+FLOPMEM+SRAM_DELAY+FLOPOUT.
REQ-027 rd_vld SHALL pulse exactly L cycles after each accepted read, one pulse per read, back-to-back reads every cycle supported.
REQ-028 When rd_vld=0, rd_dout SHALL hold 0.
REQ-029 Address >= NUMADDR SHALL be dropped (no mem_* enable, no rd_vld) and set rd_err until reset.
REQ-030 Same-address read and write in the same cycle: without bypass, rd_dout SHALL be pre-write data.

Reset
REQ-031 On rst all pipeline stages, mem_write, mem_read, rd_vld, rd_err SHALL clear to 0 next edge; addresses/data 0.
REQ-032 In-flight reads at rst assertion SHALL be discarded; no rd_vld for them after rst deasserts.
REQ-033 Memory contents SHALL NOT be reset by this block.

Configuration
REQ-034 Macro STACK_1R1W_RDWR_BYPASS_EN defined: same-cycle same-address write data SHALL be captured in an L-deep pipeline and merged, rd_dout = (bw&din)|(~bw&mem data).
REQ-035 Macro undefined: no bypass logic, REQ-030 behaviour.

Verification
REQ-036 Defaults, write adr 5 din 0xA5A5A5A5 bw all-1 -> mem_write=4'b0010, row 1; read adr 5 next cycle -> rd_vld at +2, rd_dout 0xA5A5A5A5.
REQ-037 Reads to adr 0,1,2,3 in consecutive cycles -> mem_read one-hot 1,2,4,8; four rd_vld pulses, data in order.
REQ-038 write adr 1023, read adr 1024 (BITADDR=11, NUMADDR=1024) -> read dropped, rd_err=1, stays 1 until rst.
REQ-039 Same-cycle write/read adr 7, old 0x0, din 0xFFFF0000 bw 0xFF00FF00 -> rd_dout 0x0 without macro, 0xFF000000 with macro.
REQ-040 Read issued, rst asserted next cycle -> no rd_vld; all mem_* enables 0 during rst.
REQ-041 FLOPCMD=FLOPMEM=FLOPOUT=1, SRAM_DELAY=2 -> rd_vld exactly 5 cycles after read.
